// File: rtl/reaction_timer.sv
// reaction_timer: reaction-time game controller.
// Collects DELAY_BITS bits from the LFSR stream, waits MIN_DELAY_MS + seed ms,
// raises go, then measures the player's reaction in ms (saturating at 9999).
// A press before go is reported as a false start (early).
// Optional feature macro: REACT_TIMEOUT_EN -- when defined, a round in GO that
// would count past 9999 ms ends with timeout=1; when undefined, the counter
// saturates, GO persists until stop/rst, and timeout is tied low.
module reaction_timer #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned DELAY_BITS   = 12,
  parameter int unsigned MIN_DELAY_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rnd,
  input  logic        start,
  input  logic        stop,
  output logic        go,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
);

  // Delay counter must hold MIN_DELAY_MS + (2^DELAY_BITS - 1) without overflow.
  localparam int unsigned MS_MAX  = MIN_DELAY_MS + (1 << DELAY_BITS) - 1;
  localparam int unsigned MSW_RAW = $clog2(MS_MAX + 1);
  localparam int unsigned MSW     = (MSW_RAW > DELAY_BITS + 1) ? MSW_RAW : DELAY_BITS + 1;
  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW      = (DELAY_BITS > 1) ? $clog2(DELAY_BITS) : 1;
  localparam logic [13:0] REACT_MAX = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_WAIT = 2'd2,
    S_GO   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DELAY_BITS-1:0] r_seed;
  logic [BW-1:0]         r_bitcnt;
  logic [PW-1:0]         r_presc;
  logic [MSW-1:0]        r_ms;
  logic [13:0]           r_react;

  logic                  r_go;
  logic                  r_busy;
  logic [13:0]           r_result_ms;
  logic                  r_result_valid;
  logic                  r_early;

  logic                  w_tick;
  logic                  w_seed_last;
  logic [DELAY_BITS-1:0] w_seed_next;
  logic [MSW-1:0]        w_load;
  logic                  w_fin;
  logic [13:0]           w_fin_ms;
  logic                  w_fin_early;
`ifdef REACT_TIMEOUT_EN
  logic                  r_timeout;
  logic                  w_fin_timeout;
`endif

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_seed_last = (r_bitcnt == BW'(DELAY_BITS - 1));
  assign w_load      = MSW'(MIN_DELAY_MS) + MSW'(w_seed_next);

  // Seed shift: newest rnd bit enters the LSB, so the first bit ends as MSB.
  always_comb begin
    w_seed_next    = r_seed << 1;
    w_seed_next[0] = rnd;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and end-of-round result selection.
  always_comb begin
    w_next      = r_state;
    w_fin       = 1'b0;
    w_fin_ms    = '0;
    w_fin_early = 1'b0;
`ifdef REACT_TIMEOUT_EN
    w_fin_timeout = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SEED;
      end
      S_SEED: begin
        if (stop) begin
          w_next      = S_IDLE;
          w_fin       = 1'b1;
          w_fin_early = 1'b1;
        end else if (w_seed_last) begin
          // A zero total delay (MIN_DELAY_MS=0, seed=0) skips WAIT entirely.
          w_next = (w_load == '0) ? S_GO : S_WAIT;
        end
      end
      S_WAIT: begin
        // A press on the very tick that would release go is still a false start.
        if (stop) begin
          w_next      = S_IDLE;
          w_fin       = 1'b1;
          w_fin_early = 1'b1;
        end else if (w_tick && (r_ms == MSW'(1))) begin
          w_next = S_GO;
        end
      end
      S_GO: begin
        if (stop) begin
          w_next   = S_IDLE;
          w_fin    = 1'b1;
          w_fin_ms = r_react;
        end
`ifdef REACT_TIMEOUT_EN
        else if (w_tick && (r_react == REACT_MAX)) begin
          w_next        = S_IDLE;
          w_fin         = 1'b1;
          w_fin_ms      = REACT_MAX;
          w_fin_timeout = 1'b1;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Seed, prescaler, delay and reaction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed   <= '0;
      r_bitcnt <= '0;
      r_presc  <= '0;
      r_ms     <= '0;
      r_react  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed   <= '0;
            r_bitcnt <= '0;
            r_presc  <= '0;
            r_ms     <= '0;
            r_react  <= '0;
          end
        end
        S_SEED: begin
          r_seed   <= w_seed_next;
          r_bitcnt <= r_bitcnt + BW'(1);
          if (w_seed_last) begin
            r_ms    <= w_load;
            r_presc <= '0;
            r_react <= '0;
          end
        end
        S_WAIT: begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            r_ms <= r_ms - MSW'(1);
            if (r_ms == MSW'(1)) r_react <= '0;
          end
        end
        S_GO: begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
          if (w_tick && (r_react != REACT_MAX)) r_react <= r_react + 14'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; results change only on a result_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_go           <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_ms    <= '0;
      r_early        <= 1'b0;
`ifdef REACT_TIMEOUT_EN
      r_timeout      <= 1'b0;
`endif
    end else begin
      r_go           <= (w_next == S_GO);
      r_busy         <= (w_next != S_IDLE);
      r_result_valid <= w_fin;
      if (w_fin) begin
        r_result_ms <= w_fin_ms;
        r_early     <= w_fin_early;
`ifdef REACT_TIMEOUT_EN
        r_timeout   <= w_fin_timeout;
`endif
      end
    end
  end

  assign go           = r_go;
  assign busy         = r_busy;
  assign result_ms    = r_result_ms;
  assign result_valid = r_result_valid;
  assign early        = r_early;
`ifdef REACT_TIMEOUT_EN
  assign timeout      = r_timeout;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with TICK_DIV=4, DELAY_BITS=3,
// MIN_DELAY_MS=2. Cycle n=1 is the cycle right after the edge that samples start.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rnd;
  logic        start;
  logic        stop;
  logic        go;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        early;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_timer #(
    .TICK_DIV    (4),
    .DELAY_BITS  (3),
    .MIN_DELAY_MS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rnd         (rnd),
    .start       (start),
    .stop        (stop),
    .go          (go),
    .busy        (busy),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .early       (early),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rnd_bits;     // bits for SEED cycles 1,2,3 (MSB first)
    bit          noise;        // extra start pulses in SEED, WAIT and GO
    bit          stop_in_wait; // 1: stop_at is an absolute cycle; 0: offset from go rise
    int          stop_at;
    int          exp_go;       // cycle on which go is first high (0 = never)
    logic [13:0] exp_ms;
    logic        exp_early;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_round(input int idx, input vec_t v);
    int n;
    int go_n;
    int rv_pre;
    bit done;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1; go_n = 0; rv_pre = 0; done = 1'b0;
    chk($sformatf("v%0d_busy_rise", idx), 32'(busy), 32'd1);
    while (!done && n < 400) begin
      if (go && go_n == 0) go_n = n;
      if (result_valid) rv_pre++;
      rnd   = (n >= 1 && n <= 3) ? v.rnd_bits[3-n] : 1'b0;
      start = v.noise && (n == 2 || n == 20 || (go_n != 0 && n == go_n + 2));
      stop  = v.stop_in_wait ? (n == v.stop_at) : (go_n != 0 && n == go_n + v.stop_at);
      done  = stop;
      step();
      n++;
    end
    start = 1'b0;
    stop  = 1'b0;
    rnd   = 1'b0;
    chk($sformatf("v%0d_stop_reached", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_go_cycle", idx), 32'(go_n), 32'(v.exp_go));
    chk($sformatf("v%0d_no_early_valid", idx), 32'(rv_pre), 32'd0);
    chk($sformatf("v%0d_valid", idx), 32'(result_valid), 32'd1);
    chk($sformatf("v%0d_ms", idx), 32'(result_ms), 32'(v.exp_ms));
    chk($sformatf("v%0d_early", idx), 32'(early), 32'(v.exp_early));
    chk($sformatf("v%0d_timeout", idx), 32'(timeout), 32'd0);
    chk($sformatf("v%0d_go_fall", idx), 32'(go), 32'd0);
    chk($sformatf("v%0d_busy_fall", idx), 32'(busy), 32'd0);
    step();
    chk($sformatf("v%0d_valid_pulse", idx), 32'(result_valid), 32'd0);
    chk($sformatf("v%0d_ms_held", idx), 32'(result_ms), 32'(v.exp_ms));
  endtask

  initial begin
    int n;
    int rv_cnt;

    vecs[0] = '{3'b111, 1'b0, 1'b0, 13, 40, 14'd3,  1'b0}; // nominal
    vecs[1] = '{3'b100, 1'b0, 1'b0, 5,  28, 14'd1,  1'b0}; // seed ordering
    vecs[2] = '{3'b111, 1'b0, 1'b1, 14, 0,  14'd0,  1'b1}; // false start in WAIT
    vecs[3] = '{3'b010, 1'b0, 1'b1, 2,  0,  14'd0,  1'b1}; // false start in SEED
    vecs[4] = '{3'b000, 1'b0, 1'b0, 0,  12, 14'd0,  1'b0}; // stop as go rises
    vecs[5] = '{3'b011, 1'b0, 1'b0, 3,  24, 14'd0,  1'b0}; // stop on first tick
    vecs[6] = '{3'b011, 1'b0, 1'b0, 4,  24, 14'd1,  1'b0}; // stop just after tick
    vecs[7] = '{3'b000, 1'b0, 1'b1, 11, 0,  14'd0,  1'b1}; // stop on WAIT exit tick
    vecs[8] = '{3'b111, 1'b1, 1'b0, 13, 40, 14'd3,  1'b0}; // ignored starts
    vecs[9] = '{3'b101, 1'b0, 1'b0, 40, 32, 14'd10, 1'b0}; // longer reaction

    rst = 1'b1; rnd = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_ms", 32'(result_ms), 32'd0);
    chk("rst_early", 32'(early), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_round(i, vecs[i]);

    // stop while idle: no result, held values untouched
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_valid", 32'(result_valid), 32'd0);
    chk("idle_stop_busy", 32'(busy), 32'd0);
    step();
    chk("idle_stop_valid2", 32'(result_valid), 32'd0);
    chk("idle_stop_ms_held", 32'(result_ms), 32'd10);

    // start+stop together in IDLE starts a round; then reset during GO
    rnd = 1'b0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd1);
    chk("startstop_valid", 32'(result_valid), 32'd0);
    n = 1;
    while (!go && n < 100) begin step(); n++; end
    chk("startstop_go_cycle", 32'(n), 32'd12);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_go", 32'(go), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_ms", 32'(result_ms), 32'd0);
    chk("midrst_early", 32'(early), 32'd0);
    step();
    chk("midrst_valid2", 32'(result_valid), 32'd0);
    run_round(100, vecs[0]);

    // no stop in GO: timeout or saturation
    rnd = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!go && n < 100) begin step(); n++; end
    chk("to_go_cycle", 32'(n), 32'd12);
`ifdef REACT_TIMEOUT_EN
    n = 0;
    while (!result_valid && n < 40100) begin step(); n++; end
    chk("to_cycles", 32'(n), 32'd40000);
    chk("to_ms", 32'(result_ms), 32'd9999);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_early", 32'(early), 32'd0);
    chk("to_go_fall", 32'(go), 32'd0);
    chk("to_busy_fall", 32'(busy), 32'd0);
`else
    rv_cnt = 0;
    for (int k = 0; k < 40020; k++) begin
      step();
      if (result_valid) rv_cnt++;
    end
    chk("sat_no_valid", 32'(rv_cnt), 32'd0);
    chk("sat_go_held", 32'(go), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_valid", 32'(result_valid), 32'd1);
    chk("sat_ms", 32'(result_ms), 32'd9999);
    chk("sat_timeout", 32'(timeout), 32'd0);
    chk("sat_go_fall", 32'(go), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Reaction-time game controller that consumes the single-bit pseudo-random stream from the game's LFSR stage. On each `start` it serially gathers `DELAY_BITS` random bits and waits a random delay of `MIN_DELAY_MS` plus that value in milliseconds. It then raises `go` and measures, in milliseconds, how long the player takes to press `stop`. The result feeds the score/display stage. An early press is flagged as a false start.

## Interface
- `TICK_DIV`, default 100000: clock cycles per millisecond tick (100 MHz clock).
- `DELAY_BITS`, default 12: number of `rnd` bits collected per round; random delay range is 0..2^DELAY_BITS-1 ms.
- `MIN_DELAY_MS`, default 1000: fixed delay offset in ms.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `rnd` in 1: pseudo-random bit from the LFSR stage, one new bit per cycle.
- `start` in 1: single-cycle pulse, already debounced, that begins a round.
- `stop` in 1: single-cycle pulse, already debounced, for the player press.
- `go` out 1: high while the player must react (GO state).
- `busy` out 1: high in any state other than IDLE.
- `result_ms` out 14: last reaction time in ms, 0..9999; held until the next result.
- `result_valid` out 1: one-cycle pulse when `result_ms`/`early`/`timeout` update.
- `early` out 1: last round was a false start; held until the next `result_valid`.
- `timeout` out 1: last round timed out; held until the next `result_valid`. Constant 0 when the timeout feature is compiled out.

## Operation
- FSM states: IDLE, SEED, WAIT, GO.
- IDLE:
  - `start` leads to SEED; shift register, bit counter and outputs other than the held results are cleared.
  - `stop` is ignored.
  - `start` and `stop` in the same cycle: `start` wins.
- SEED:
  - Lasts exactly `DELAY_BITS` cycles.
  - Each cycle shifts `rnd` into the seed register LSB, so the first captured bit ends up as the MSB.
  - On the last cycle, load the ms counter with `MIN_DELAY_MS` + seed (width `DELAY_BITS`+1 or wider, no overflow), clear the prescaler, and go to WAIT.
- WAIT:
  - The prescaler counts 0..`TICK_DIV`-1; a tick occurs when it equals `TICK_DIV`-1.
  - Each tick decrements the ms counter.
  - The tick that takes the counter to 0 moves the FSM to GO, clears the prescaler, and clears the reaction counter.
- GO:
  - `go`=1.
  - Each tick increments the reaction counter, which saturates at 9999.
  - `stop` leads to IDLE with `result_ms` = reaction counter, `early`=0, `timeout`=0, and a `result_valid` pulse.
- False start: `stop` sampled in SEED or WAIT (including the cycle WAIT exits) leads to IDLE with `result_ms`=0, `early`=1, `timeout`=0, and a `result_valid` pulse.
- `start` while `busy` is ignored.
- Reset values:
  - state IDLE.
  - `go`, `busy`, `result_valid`, `early`, `timeout` = 0.
  - `result_ms` = 0.
  - All internal counters = 0.
- `rst` mid-round aborts immediately to reset values; no `result_valid` is issued.

## Timing
- All outputs are registered.
- `busy` rises on the cycle after `start` is sampled.
- SEED occupies `DELAY_BITS` cycles.
- WAIT occupies exactly (`MIN_DELAY_MS`+seed)×`TICK_DIV` cycles.
- `go` rises `DELAY_BITS` + (`MIN_DELAY_MS`+seed)×`TICK_DIV` + 1 cycles after the edge that sampled `start`.
- `result_valid`, `result_ms`, `early` and `timeout` update on the cycle after `stop` is sampled, at the same edge where `go` and `busy` fall.
- A `stop` in the same cycle as a GO tick reports the pre-increment count.
- The next `start` is accepted on the first cycle `busy`=0.

## Configuration
- Macro: `REACT_TIMEOUT_EN`.
- Defined:
  - In GO, the tick that would make the counter exceed 9999 ends the round.
  - Result: IDLE, `result_ms`=9999, `timeout`=1, `early`=0, `result_valid` pulse.
- Undefined:
  - The counter saturates at 9999 and GO persists until `stop` or `rst`.
  - `timeout` is tied to 0.

## Test plan
All scenarios use `TICK_DIV`=4, `DELAY_BITS`=3, `MIN_DELAY_MS`=2.
- Nominal round: `rnd` held 1 gives seed 7 and a 9 ms delay. Pulse `start`, then `go` rises 40 cycles later. Pulse `stop` 13 cycles after `go` rises: `result_ms`=3, `early`=0, one `result_valid` pulse.
- Seed ordering: `rnd` = 1,0,0 on the three SEED cycles gives seed 4. WAIT lasts 24 cycles and `go` rises 28 cycles after `start`.
- False start: `stop` 10 cycles into WAIT gives `early`=1, `result_ms`=0, `result_valid` pulse, `go` never rises, `busy`=0 next cycle.
- Ignored inputs:
  - `start` pulses during SEED, WAIT and GO do not change timing.
  - `stop` in IDLE produces no `result_valid`.
  - `start` and `stop` together in IDLE start a round.
- Reset mid-round: `rst` during GO forces all outputs to 0 next cycle with no `result_valid`. A subsequent `start` runs a normal round.
- Timeout: with `REACT_TIMEOUT_EN` defined and no `stop`, the round ends after 10000 ticks in GO with `result_ms`=9999, `timeout`=1. With the macro undefined, `go` stays high and the counter holds at 9999.
